difftest_step_batcher: RTL

DIFFTEST_STEP_BATCHER -- requirements
Module: difftest_step_batcher

---
 rtl/difftest_step_batcher.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/difftest_step_batcher.sv
// difftest_step_batcher
//
// Groups per-cycle instruction commits into batched "step" events for a
// difftest consumer. It counts committed lanes every cycle and releases the
// accumulated count when the batch threshold is reached, when the
// accumulation has aged TIMEOUT cycles, or on a trap or flush event. If the
// consumer is not ready at release time, the count is held and keeps
// accumulating until the consumer accepts it.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   commit_valid  per-lane commit valid bits for this cycle
//   trap_valid    trap / end-of-program event, forces a release
//   flush_req     external flush request, forces a release
//   step_ready    consumer can accept a step this cycle
//   difftest_step released event count, one cycle wide (0 = no step)
//   step_pending  accumulated, not yet released count
//   overflow_err  sticky flag, set when the count saturated
module difftest_step_batcher #(
    parameter int COMMIT_WIDTH = 6,
    parameter int STEP_WIDTH   = 8,
    parameter int BATCH_SIZE   = 64,
    parameter int TIMEOUT      = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic                    trap_valid,
    input  logic                    flush_req,
    input  logic                    step_ready,
    output logic [STEP_WIDTH-1:0]   difftest_step,
    output logic [STEP_WIDTH-1:0]   step_pending,
    output logic                    overflow_err
);

    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam int SUM_W = STEP_WIDTH + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [STEP_WIDTH-1:0] STEP_MAX   = {STEP_WIDTH{1'b1}};
    localparam logic [STEP_WIDTH-1:0] BATCH_THR  = STEP_WIDTH'(BATCH_SIZE);
    localparam logic [TMO_W-1:0]      TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state;
    logic [STEP_WIDTH-1:0]  acc;
    logic [TMO_W-1:0]       tmo;

    logic [CNT_W-1:0]       n;
    logic [SUM_W-1:0]       sum;
    logic [STEP_WIDTH-1:0]  acc_next;
    logic                   sum_overflow;
    logic                   release_cond;

    // Clamp the one-bit-wider sum to the largest representable count.
    function automatic logic [STEP_WIDTH-1:0] saturate(input logic [SUM_W-1:0] value);
        if (value[SUM_W-1]) begin
            return STEP_MAX;
        end
        return value[STEP_WIDTH-1:0];
    endfunction

    always_comb begin
        n = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            n = n + CNT_W'(commit_valid[i]);
        end
    end

    assign sum          = {1'b0, acc} + SUM_W'(n);
    assign sum_overflow = sum[SUM_W-1];
    assign acc_next     = saturate(sum);

    // Every release source except the threshold requires something to send;
    // the threshold itself is always >= 1, so it implies a non-zero count.
    assign release_cond = (acc_next >= BATCH_THR) ||
                          ((acc_next != '0) &&
                           ((tmo == TMO_LAST) || trap_valid || flush_req));

    assign step_pending = acc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            acc           <= '0;
            tmo           <= '0;
            difftest_step <= '0;
            overflow_err  <= 1'b0;
        end else begin
            difftest_step <= '0;
            if (sum_overflow) begin
                overflow_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tmo <= '0;
                    if (release_cond) begin
                        if (step_ready) begin
                            difftest_step <= acc_next;
                            acc           <= '0;
                        end else begin
                            state <= HOLD;
                            acc   <= acc_next;
                        end
                    end else if (n != '0) begin
                        state <= ACCUM;
                        acc   <= acc_next;
                    end
                end

                ACCUM: begin
                    if (release_cond) begin
                        tmo <= '0;
                        if (step_ready) begin
                            state         <= IDLE;
                            difftest_step <= acc_next;
                            acc           <= '0;
                        end else begin
                            state <= HOLD;
                            acc   <= acc_next;
                        end
                    end else begin
                        // tmo cannot pass TMO_LAST here: reaching it releases.
                        tmo <= tmo + 1'b1;
                        acc <= acc_next;
                    end
                end

                HOLD: begin
                    // Once held, only consumer readiness matters; the
                    // threshold/timeout/trap sources are already satisfied.
                    if (step_ready) begin
                        state         <= IDLE;
                        difftest_step <= acc_next;
                        acc           <= '0;
                        tmo           <= '0;
                    end else begin
                        acc <= acc_next;
                        if (tmo != TMO_LAST) begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    tmo   <= '0;
                end
            endcase
        end
    end

endmodule
